// File: rtl/ysyx_23060184_rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: requester indices
// and default register address/data widths.
package ysyx_23060184_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    REQ_EXU = 1'b0,
    REQ_LSU = 1'b1
  } req_idx_e;

endpackage

// File: rtl/ysyx_23060184_rf_wb_arbiter_arb2.sv
// Two-way writeback grant: fixed priority to the LSU by default, round-robin on
// contention when YSYX_23060184_RR_ARB_EN is defined.
module ysyx_23060184_wb_arb2
  import ysyx_23060184_pkg::*;
(
`ifdef YSYX_23060184_RR_ARB_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  req_idx_e sel;

`ifdef YSYX_23060184_RR_ARB_EN
  // ptr names the requester favoured at the next contention
  req_idx_e ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= REQ_EXU;
    end else if (valid0 && valid1) begin
      ptr <= (sel == REQ_EXU) ? REQ_LSU : REQ_EXU;
    end
  end

  always_comb begin
    sel = REQ_EXU;
    if (valid0 && valid1) sel = ptr;
    else if (valid1)      sel = REQ_LSU;
  end
`else
  always_comb begin
    sel = valid1 ? REQ_LSU : REQ_EXU;
  end
`endif

  assign grant0 = valid0 && (sel == REQ_EXU);
  assign grant1 = valid1 && (sel == REQ_LSU);

endmodule

// File: rtl/ysyx_23060184_rf_wb_arbiter.sv
// Register-file writeback arbiter with a busy-bit scoreboard for issue hazards.
// Define YSYX_23060184_RR_ARB_EN for round-robin arbitration between EXU and LSU.
module ysyx_23060184_rf_wb_arbiter
  import ysyx_23060184_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic                  iss_wen,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] iss_rs1,
  input  logic [ADDR_WIDTH-1:0] iss_rs2,
  output logic                  iss_stall,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wen,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wen,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0]       busy, busy_nxt;
  logic                  grant0, grant1;
  logic                  hs, iss_set;
  logic                  g_wen;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;

  ysyx_23060184_wb_arb2 u_arb (
`ifdef YSYX_23060184_RR_ARB_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  assign req0_ready = !reset && grant0;
  assign req1_ready = !reset && grant1;
  assign hs         = req0_ready || req1_ready;

  assign g_wen  = req1_ready ? req1_wen  : req0_wen;
  assign g_addr = req1_ready ? req1_addr : req0_addr;
  assign g_data = req1_ready ? req1_data : req0_data;

  assign iss_stall = !reset && iss_valid &&
                     (busy[iss_rs1] || busy[iss_rs2] || (iss_wen && busy[iss_rd]));
  assign iss_set   = iss_valid && iss_wen && !iss_stall && (iss_rd != '0);

  // Clear before set so a new producer of the same register keeps it busy
  always_comb begin
    busy_nxt = busy;
    if (hs && g_wen) busy_nxt[g_addr] = 1'b0;
    if (iss_set)     busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      busy   <= busy_nxt;
      rf_wen <= hs && g_wen && (g_addr != '0);
      if (hs) begin
        rf_waddr <= g_addr;
        rf_wdata <= g_data;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_rf_wb_arbiter.sv
// Directed and randomized bench for the writeback arbiter against a behavioural
// scoreboard/arbitration model.
module tb_ysyx_23060184_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        iss_valid, iss_wen;
  logic [4:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        req0_valid, req0_ready, req0_wen;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req1_valid, req1_ready, req1_wen;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          mb[32];
  int          mfav;
  bit          mrfw;
  logic [4:0]  mra;
  logic [31:0] mrd;

  always #5 clk = ~clk;

  ysyx_23060184_rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 0; iss_wen = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    req0_valid = 0; req0_wen = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_wen = 0; req1_addr = 0; req1_data = 0;
  endtask

  // One cycle: check combinational outputs, clock, update model, check registered outputs.
  task automatic step();
    int g;
    bit est;
    #1;
    est = !reset && iss_valid && (mb[iss_rs1] || mb[iss_rs2] || (iss_wen && mb[iss_rd]));
    g = -1;
    if (req0_valid && req1_valid) begin
`ifdef YSYX_23060184_RR_ARB_EN
      g = mfav;
`else
      g = 1;
`endif
    end else if (req0_valid) g = 0;
    else if (req1_valid)     g = 1;
    if (reset) g = -1;
    chk("iss_stall", 32'(iss_stall), 32'(est));
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    @(posedge clk);
    if (reset) begin
      foreach (mb[i]) mb[i] = 0;
      mrfw = 0; mra = 0; mrd = 0; mfav = 0;
    end else begin
      if (req0_valid && req1_valid) mfav = 1 - g;
      mrfw = 0;
      if (g >= 0) begin
        logic       w;
        logic [4:0] a;
        w   = (g == 1) ? req1_wen  : req0_wen;
        a   = (g == 1) ? req1_addr : req0_addr;
        mrd = (g == 1) ? req1_data : req0_data;
        mra = a;
        mrfw = w && (a != 0);
        if (w) mb[a] = 0;
      end
      if (iss_valid && iss_wen && !est && iss_rd != 0) mb[iss_rd] = 1;
    end
    @(negedge clk);
    chk("rf_wen", 32'(rf_wen), 32'(mrfw));
    chk("rf_waddr", 32'(rf_waddr), 32'(mra));
    chk("rf_wdata", rf_wdata, mrd);
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    step(); step();
    reset = 0;
    step();

`ifdef YSYX_23060184_RR_ARB_EN
    // contention right after reset: alternate starting with req0
    req0_valid = 1; req0_wen = 1; req0_addr = 3; req0_data = 32'h11;
    req1_valid = 1; req1_wen = 1; req1_addr = 4; req1_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_grant", 32'(req1_ready), 32'(i % 2));
      step();
      chk("rr_waddr", 32'(rf_waddr), (i % 2) ? 32'd4 : 32'd3);
    end
    idle();
`else
    req0_valid = 1; req0_wen = 1; req0_addr = 3; req0_data = 32'h11;
    req1_valid = 1; req1_wen = 1; req1_addr = 4; req1_data = 32'h22;
    #1 chk("fix_r1_first", 32'(req1_ready), 32'd1);
    step();
    chk("fix_wr1_addr", 32'(rf_waddr), 32'd4);
    chk("fix_wr1_data", rf_wdata, 32'h22);
    req1_valid = 0;
    step();
    chk("fix_wr2_addr", 32'(rf_waddr), 32'd3);
    chk("fix_wr2_data", rf_wdata, 32'h11);
    idle();
`endif

    // RAW hazard released one cycle after the writeback
    iss_valid = 1; iss_wen = 1; iss_rd = 5; iss_rs1 = 1; iss_rs2 = 2;
    step();
    iss_wen = 0; iss_rd = 0; iss_rs1 = 5; iss_rs2 = 0;
    #1 chk("raw_stall", 32'(iss_stall), 32'd1);
    step();
    req0_valid = 1; req0_wen = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
    step();
    chk("raw_rf_wen", 32'(rf_wen), 32'd1);
    chk("raw_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("raw_rf_wdata", rf_wdata, 32'hDEADBEEF);
    req0_valid = 0;
    #1 chk("raw_release", 32'(iss_stall), 32'd0);
    step();
    idle();

    // same-edge set and clear: new producer wins
    iss_valid = 1; iss_wen = 1; iss_rd = 7; iss_rs1 = 1; iss_rs2 = 2;
    req1_valid = 1; req1_wen = 1; req1_addr = 7; req1_data = 32'h77;
    step();
    idle();
    iss_valid = 1; iss_rs2 = 7;
    #1 chk("waw_keep_busy", 32'(iss_stall), 32'd1);
    step();
    iss_valid = 0;
    req1_valid = 1; req1_wen = 1; req1_addr = 7; req1_data = 32'h78;
    step();
    idle();

    // writes to x0 are swallowed; rd=0 never stalls
    req0_valid = 1; req0_wen = 1; req0_addr = 0; req0_data = 32'hFFFFFFFF;
    #1 chk("x0_ready", 32'(req0_ready), 32'd1);
    step();
    chk("x0_rf_wen", 32'(rf_wen), 32'd0);
    idle();
    iss_valid = 1; iss_wen = 1; iss_rd = 0;
    step();
    #1 chk("x0_no_stall", 32'(iss_stall), 32'd0);
    step();
    idle();

    // reset discards scoreboard state and in-flight requests
    iss_valid = 1; iss_wen = 1; iss_rd = 9; iss_rs1 = 1; iss_rs2 = 2;
    step();
    idle();
    reset = 1; req0_valid = 1; req0_wen = 1; req0_addr = 9; req0_data = 32'h99;
    #1 chk("rst_ready0", 32'(req0_ready), 32'd0);
    step();
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    idle();
    reset = 0;
    iss_valid = 1; iss_rs1 = 9;
    #1 chk("rst_busy_clr", 32'(iss_stall), 32'd0);
    step();
    idle();

    // randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      iss_valid  = 1'($urandom_range(0, 1));
      iss_wen    = 1'($urandom_range(0, 1));
      iss_rd     = 5'($urandom_range(0, 7));
      iss_rs1    = 5'($urandom_range(0, 7));
      iss_rs2    = 5'($urandom_range(0, 7));
      req0_valid = 1'($urandom_range(0, 1));
      req0_wen   = ($urandom_range(0, 3) != 0);
      req0_addr  = 5'($urandom_range(0, 7));
      req0_data  = $urandom;
      req1_valid = 1'($urandom_range(0, 1));
      req1_wen   = ($urandom_range(0, 3) != 0);
      req1_addr  = 5'($urandom_range(0, 7));
      req1_data  = $urandom;
      reset      = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
